module_despliegue_7seg: RTL and testbench
=========================================

# module_despliegue_7seg

Scanning driver for a two-digit common-anode 7-segment display. It is the consumer of the held units/tens BCD operands (`op_u`, `op_d`) produced by the display-holding register stage. It snapshots both digits at a frame boundary, time-multiplexes them onto one shared segment bus with a dead cycle between digits, and decodes BCD to active-low segments.

## Interface
- `REFRESH_DIV`, default 27000: cycles each digit stays lit. Minimum 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `op_u`  in  4  units BCD digit from the holding register.
- `op_d`  in  4  tens BCD digit from the holding register.
- `cargar`  in  1  single-cycle strobe: new operands are valid and must be committed.
- `cargado`  out  1  one-cycle pulse when a pending load is committed to the shadow registers.
- `anodo`  out  2  active-low digit enables: bit 0 = units, bit 1 = tens.
- `seg`  out  7  active-low segments {g,f,e,d,c,b,a}.

## Operation
- Shadow registers `sh_u` and `sh_d` hold the displayed digits. They change only at a frame commit.
- Pending flag:
  - Set by `cargar`.
  - Multiple strobes before a commit collapse into one commit.
- Scan FSM states: `UNI`, `APAGA_U`, `DEC`, `APAGA_D`.
  - `UNI` → `APAGA_U` when the refresh counter reaches `REFRESH_DIV-1`.
  - `APAGA_U` → `DEC` after 1 cycle.
  - `DEC` → `APAGA_D` when the counter reaches `REFRESH_DIV-1`.
  - `APAGA_D` → `UNI` after 1 cycle.
- Refresh counter:
  - Counts 0..`REFRESH_DIV-1` only in `UNI` and `DEC`.
  - Cleared on entry to either state.
- Commit happens on the `APAGA_D`→`UNI` edge when pending is set, or when `cargar` is high on that same edge. On commit:
  - `sh_u` ← `op_u` and `sh_d` ← `op_d`, sampled at the commit edge, not at strobe time.
  - Pending clears.
  - `cargado` = 1 for exactly that cycle.
- A `cargar` that arrives on the commit edge is consumed by that commit and leaves no pending flag.
- Outputs per state:
  - `UNI`: `anodo`=2'b10, `seg`=dec(`sh_u`).
  - `DEC`: `anodo`=2'b01, `seg`=dec(`sh_d`).
  - `APAGA_*`: `anodo`=2'b11, `seg`=7'b1111111.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10–15 display a dash: 0111111.

## Timing
- Reset values:
  - State `APAGA_D`, counter 0, `sh_u`=`sh_d`=0, pending 0.
  - `anodo`=2'b11, `seg`=7'b1111111, `cargado`=0.
- First rising edge after reset release enters `UNI` and displays units 0.
- Outputs are registered and update on the same edge as the state transition. There are no combinational paths from inputs to outputs.
- Each digit is lit for exactly `REFRESH_DIV` cycles, followed by 1 blank cycle. Frame length is 2·`REFRESH_DIV`+2 cycles.
- Load latency, from `cargar` to new digits visible on `seg`: from 1 cycle up to one full frame. The new digits appear in the first `UNI` slot after the commit.
- Reset asserted mid-frame forces all outputs to their reset values immediately (asynchronously) and discards any pending load.

## Configuration
- `BLANK_CERO_EN` defined: when `sh_d`==0, the `DEC` slot drives `anodo`=2'b11 and `seg`=7'b1111111 (leading-zero blank). Slot timing is unchanged.
- `BLANK_CERO_EN` undefined: tens digit 0 is displayed as "0".
- Units digit is never blanked in either case.

## Test plan
All scenarios use `REFRESH_DIV`=4 and a 10-cycle frame.
- Reset release, no load → `UNI` shows `seg`=1000000 with `anodo`=10 for 4 cycles, then 1 blank cycle; `DEC` shows 1000000 (macro off) or blank (macro on).
- `op_u`=7, `op_d`=3, `cargar` pulsed mid-`UNI` → `cargado` pulses at the next `APAGA_D`→`UNI` edge; that `UNI` slot shows 1111000, the `DEC` slot shows 0110000.
- Three `cargar` pulses in one frame with `op_u` changing 1→2→5 → single `cargado` pulse; displayed units digit is 5 (value at the commit edge).
- `op_u`=12 committed → units slot shows 0111111.
- `cargar` high exactly on the commit edge → commit that edge and no second `cargado` in the next frame.
- Assert `rst` during `DEC` with a load pending → `anodo`=11 and `seg`=1111111 immediately; after release the display shows 0/0 and no commit occurs.

Source files
------------

// File: rtl/module_despliegue_7seg_if.sv
// Operand/display bus between the holding-register stage and the 7-segment scan driver.
// The producer drives op_u/op_d/cargar. The display driver returns cargado, anodo and seg.
interface module_despliegue_7seg_if;
    logic [3:0] op_u;
    logic [3:0] op_d;
    logic       cargar;
    logic       cargado;
    logic [1:0] anodo;
    logic [6:0] seg;

    modport master (output op_u, op_d, cargar, input cargado, anodo, seg);
    modport slave  (input op_u, op_d, cargar, output cargado, anodo, seg);
endinterface

// File: rtl/module_despliegue_7seg.sv
// Two-digit common-anode 7-segment scan driver with frame-boundary operand commit.
// Optional macro BLANK_CERO_EN blanks a leading zero in the tens slot.
module module_despliegue_7seg #(
    parameter int REFRESH_DIV = 27000
) (
    input  logic                        clk,
    input  logic                        rst,
    module_despliegue_7seg_if.slave     bus,
    output logic [1:0]                  dbg_estado
);
    // Load handshake: cargar is a one-cycle strobe whose op_u/op_d are sampled only
    // when the load commits at the APAGA_D->UNI edge. cargado pulses for that cycle.
    // A strobe cannot be refused. Further strobes before the commit merge into it.

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

`ifdef BLANK_CERO_EN
    localparam bit BLANK_CERO = 1'b1;
`else
    localparam bit BLANK_CERO = 1'b0;
`endif

    typedef enum logic [1:0] {
        UNI     = 2'd0,
        APAGA_U = 2'd1,
        DEC     = 2'd2,
        APAGA_D = 2'd3
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic [3:0]    sh_u;
    logic [3:0]    sh_d;
    logic          pend;
    logic          commit;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // A strobe on the commit edge itself is taken by that commit.
    assign commit     = (estado == APAGA_D) && (pend || bus.cargar);
    assign dbg_estado = estado;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado      <= APAGA_D;
            cnt         <= '0;
            sh_u        <= 4'd0;
            sh_d        <= 4'd0;
            pend        <= 1'b0;
            bus.cargado <= 1'b0;
            bus.anodo   <= 2'b11;
            bus.seg     <= 7'b1111111;
        end else begin
            bus.cargado <= 1'b0;
            if (commit)
                pend <= 1'b0;
            else if (bus.cargar)
                pend <= 1'b1;

            case (estado)
                UNI: begin
                    if (cnt == CNT_MAX) begin
                        estado    <= APAGA_U;
                        cnt       <= '0;
                        bus.anodo <= 2'b11;
                        bus.seg   <= 7'b1111111;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                APAGA_U: begin
                    estado <= DEC;
                    if (BLANK_CERO && (sh_d == 4'd0)) begin
                        bus.anodo <= 2'b11;
                        bus.seg   <= 7'b1111111;
                    end else begin
                        bus.anodo <= 2'b01;
                        bus.seg   <= dec7(sh_d);
                    end
                end
                DEC: begin
                    if (cnt == CNT_MAX) begin
                        estado    <= APAGA_D;
                        cnt       <= '0;
                        bus.anodo <= 2'b11;
                        bus.seg   <= 7'b1111111;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                APAGA_D: begin
                    estado    <= UNI;
                    bus.anodo <= 2'b10;
                    // The units slot must show the freshly committed digit on its first cycle.
                    if (commit) begin
                        sh_u        <= bus.op_u;
                        sh_d        <= bus.op_d;
                        bus.cargado <= 1'b1;
                        bus.seg     <= dec7(bus.op_u);
                    end else begin
                        bus.seg <= dec7(sh_u);
                    end
                end
                default: begin
                    estado <= APAGA_D;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_module_despliegue_7seg.sv
// Self-checking bench for module_despliegue_7seg with REFRESH_DIV=4 (10-cycle frame).
// The reference model works from the frame position of each edge since reset release.
module tb_module_despliegue_7seg;
    localparam int D = 4;
    localparam int F = 2 * D + 2;
    localparam logic [6:0] SEG_TBL [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic       clk;
    logic       rst;
    logic [1:0] dbg_estado;

    module_despliegue_7seg_if bus ();

    module_despliegue_7seg #(.REFRESH_DIV(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .dbg_estado (dbg_estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         k     = 0;
    bit         m_pend;
    logic [3:0] m_u;
    logic [3:0] m_d;
    logic [9:0] exp_q[$];
    logic [9:0] got;
    logic [9:0] exp_v;

    task automatic model_reset();
        k      = 0;
        m_pend = 1'b0;
        m_u    = 4'd0;
        m_d    = 4'd0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs, let one rising edge happen, queue the expected outputs.
    task automatic tick(input logic [3:0] u, input logic [3:0] d, input logic c);
        int         ph;
        logic       cg;
        logic [1:0] an;
        logic [6:0] sg;
        bus.op_u   = u;
        bus.op_d   = d;
        bus.cargar = c;
        @(posedge clk);
        k++;
        ph = (k - 1) % F;
        cg = 1'b0;
        if (ph == 0 && (m_pend || c)) begin
            m_u    = u;
            m_d    = d;
            m_pend = 1'b0;
            cg     = 1'b1;
        end else if (c) begin
            m_pend = 1'b1;
        end
        if (ph < D) begin
            an = 2'b10;
            sg = SEG_TBL[m_u];
        end else if (ph == D || ph == F - 1) begin
            an = 2'b11;
            sg = 7'h7f;
        end else begin
`ifdef BLANK_CERO_EN
            if (m_d == 4'd0) begin
                an = 2'b11;
                sg = 7'h7f;
            end else begin
                an = 2'b01;
                sg = SEG_TBL[m_d];
            end
`else
            an = 2'b01;
            sg = SEG_TBL[m_d];
`endif
        end
        exp_q.push_back({cg, an, sg});
        #1;
    endtask

    // Idle ticks until the next edge is a frame commit edge.
    task automatic align_frame();
        while (k % F != 0) tick(4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        bus.cargar = 1'b0;
        bus.op_u   = 4'd0;
        bus.op_d   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        got = {bus.cargado, bus.anodo, bus.seg};
        n_vec++;
        if (got !== {1'b0, 2'b11, 7'h7f}) begin
            n_err++;
            $display("FAIL reset_out: got %b exp %b", got, {1'b0, 2'b11, 7'h7f});
        end
        n_vec++;
        if (dbg_estado !== 2'd3) begin
            n_err++;
            $display("FAIL reset_state: got %0d exp 3", dbg_estado);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_idle();
        repeat (2 * F) begin
            tick(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
            got   = {bus.cargado, bus.anodo, bus.seg};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL idle k=%0d: got %b exp %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_load_basic();
        align_frame();
        for (int i = 0; i < 3 * F; i++) begin
            tick(4'd7, 4'd3, (i == 2));
            got   = {bus.cargado, bus.anodo, bus.seg};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL load_basic k=%0d: got %b exp %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_multi_strobe();
        int         pulses;
        logic [3:0] u;
        logic       c;
        align_frame();
        exp_q.delete();
        tick(4'd0, 4'd0, 1'b0);
        void'(exp_q.pop_front());
        for (int ph = 1; ph < F; ph++) begin
            u = (ph < 3) ? 4'd1 : (ph < 6) ? 4'd2 : 4'd5;
            c = (ph == 1 || ph == 3 || ph == 6);
            tick(u, 4'd6, c);
            got   = {bus.cargado, bus.anodo, bus.seg};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL multi_strobe k=%0d: got %b exp %b", k, got, exp_v);
            end
        end
        pulses = 0;
        for (int i = 0; i < 2 * F; i++) begin
            tick(4'd5, 4'd6, 1'b0);
            if (bus.cargado === 1'b1) pulses++;
            got   = {bus.cargado, bus.anodo, bus.seg};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL multi_strobe k=%0d: got %b exp %b", k, got, exp_v);
            end
        end
        n_vec++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL multi_strobe_pulses: got %0d exp 1", pulses);
        end
    endtask

    task automatic test_dash();
        align_frame();
        exp_q.delete();
        for (int i = 0; i < 2 * F; i++) begin
            tick(4'd12, 4'd9, (i == 3));
            got   = {bus.cargado, bus.anodo, bus.seg};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL dash k=%0d: got %b exp %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_commit_edge();
        int pulses;
        align_frame();
        exp_q.delete();
        tick(4'd4, 4'd8, 1'b1);
        got   = {bus.cargado, bus.anodo, bus.seg};
        exp_v = exp_q.pop_front();
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL commit_edge: got %b exp %b", got, exp_v);
        end
        pulses = 0;
        for (int i = 1; i < 2 * F; i++) begin
            tick(4'd1, 4'd1, 1'b0);
            if (bus.cargado === 1'b1) pulses++;
            got   = {bus.cargado, bus.anodo, bus.seg};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL commit_edge k=%0d: got %b exp %b", k, got, exp_v);
            end
        end
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL commit_edge_second: got %0d extra pulses exp 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        align_frame();
        tick(4'd0, 4'd0, 1'b0);
        tick(4'd8, 4'd9, 1'b1);
        for (int ph = 2; ph <= D + 2; ph++) tick(4'd8, 4'd9, 1'b0);
        exp_q.delete();
        #2;
        rst = 1'b0;
        #1;
        got = {bus.cargado, bus.anodo, bus.seg};
        n_vec++;
        if (got !== {1'b0, 2'b11, 7'h7f}) begin
            n_err++;
            $display("FAIL reset_mid_async: got %b exp %b", got, {1'b0, 2'b11, 7'h7f});
        end
        model_reset();
        bus.cargar = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2 * F; i++) begin
            tick(4'd8, 4'd9, 1'b0);
            got   = {bus.cargado, bus.anodo, bus.seg};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL reset_mid k=%0d: got %b exp %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            tick(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0));
            got   = {bus.cargado, bus.anodo, bus.seg};
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL random k=%0d: got %b exp %b", k, got, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_basic();
        test_multi_strobe();
        test_dash();
        test_commit_edge();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
